mips_cpu_muldiv: RTL and testbench

Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU with a start/busy/done handshake, and services MTHI/MTLO writes. It sits beside the ALU. The CPU issues an operation from its DECODE stage and stalls any MFHI/MFLO until `busy` is low. The operand width is generic, so the same unit serves 32-bit and reduced-width test builds.

---
 rtl/mips_cpu_muldiv.sv | 156 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, start/busy/done handshake and MTHI/MTLO writes while idle.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div_q;
  logic               neg_q;      // sign of product or quotient
  logic               rem_neg_q;  // sign of remainder
  logic               div0_q;
  logic [WIDTH-1:0]   a_orig_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;      // product accumulator; low half doubles as dividend/quotient
  logic [WIDTH:0]     rem_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ge    = ~div_diff[WIDTH+1];
    rem_next  = div_ge ? div_diff[WIDTH:0] : div_shift;
    quo_next  = {acc_q[WIDTH-2:0], div_ge};

    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  end

  // NOTE: reset is checked before clk_enable so a reset is never masked by a stalled pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      a_orig_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (clk_enable) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            cnt       <= '0;
            is_div_q  <= op[1];
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= (b == '0);
            a_orig_q  <= a;
            rem_q     <= '0;
            if (op[1]) begin
              opnd_q <= b_mag;
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
            end
          end else begin
            if (hi_write) hi <= wdata;
            if (lo_write) lo <= wdata;
          end
        end

        RUN: begin
          if (is_div_q) begin
            acc_q[WIDTH-1:0] <= quo_next;
            rem_q            <= rem_next;
          end else begin
            acc_q <= mul_next;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
        end

        FIXUP: begin
          if (!is_div_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div0_q) begin
            hi <= a_orig_q;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: a WIDTH=32 unit for the main scenarios and a
// WIDTH=8 unit swept over a table of corner operands against a behavioural model.
module tb_mips_cpu_muldiv;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_enable;
  logic        start32, hw32, lw32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;
  logic        start8, hw8, lw8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  mips_cpu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start32), .op(op32),
    .a(a32), .b(b32), .hi_write(hw32), .lo_write(lw32), .wdata(wd32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mips_cpu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start8), .op(op8),
    .a(a8), .b(b8), .hi_write(hw8), .lo_write(lw8), .wdata(wd8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on the 32-bit unit; lat counts edges from the start edge until done is seen.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int pause_at, output int lat, output int busy_cycles);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    busy_cycles = 0;
    tick();
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 200) begin
      if (busy32) busy_cycles++;
      if (lat == pause_at) begin
        clk_enable = 1'b0;
        repeat (5) begin tick(); lat++; end
        clk_enable = 1'b1;
      end
      tick();
      lat++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [15:0] model8(input logic [1:0] o, input logic [7:0] x,
                                         input logic [7:0] y);
    int sx, sy, ux, uy, p, q, r;
    sx = $signed(x); sy = $signed(y);
    ux = x;          uy = y;
    case (o)
      2'b00: begin p = sx * sy; return p[15:0]; end
      2'b01: begin p = ux * uy; return p[15:0]; end
      2'b10: begin
        if (y == 8'd0) return {x, 8'hFF};
        q = sx / sy; r = sx % sy;
        return {r[7:0], q[7:0]};
      end
      default: begin
        if (y == 8'd0) return {x, 8'hFF};
        q = ux / uy; r = ux % uy;
        return {r[7:0], q[7:0]};
      end
    endcase
  endfunction

  task automatic test_reset();
    checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      errors++;
      $display("FAIL reset32 busy=%b done=%b hi=%h lo=%h want all zero", busy32, done32, hi32, lo32);
    end
    checks++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b hi=%h lo=%h want all zero", busy8, done8, hi8, lo8);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_multu();
    int lat, bc;
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi32, lo32);
    end
    checks++;
    if (lat !== 34 || bc !== 33) begin
      errors++;
      $display("FAIL multu_timing latency=%0d busy=%0d want 34/33", lat, bc);
    end
    tick();
    checks++;
    if (done32 !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b want 0 one cycle later", done32);
    end
  endtask

  // Issued back to back: each start is raised in the cycle the previous done is high.
  task automatic test_signs();
    int lat, bc;
    run32(2'b00, 32'hFFFF_FFFD, 32'd5, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFF1 || lat !== 34) begin
      errors++;
      $display("FAIL mult_neg got %h_%h lat=%0d want ffffffff_fffffff1 lat=34", hi32, lo32, lat);
    end
    run32(2'b10, 32'hFFFF_FFF9, 32'd2, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 34) begin
      errors++;
      $display("FAIL div_neg got %h_%h lat=%0d want ffffffff_fffffffd lat=34", hi32, lo32, lat);
    end
    run32(2'b11, 32'd7, 32'd2, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'h0000_0001_0000_0003 || lat !== 34) begin
      errors++;
      $display("FAIL divu_small got %h_%h lat=%0d want 00000001_00000003 lat=34", hi32, lo32, lat);
    end
  endtask

  task automatic test_corner_div();
    int lat, bc;
    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL div_overflow got %h_%h want 00000000_80000000", hi32, lo32);
    end
    run32(2'b11, 32'h1234, 32'd0, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'h0000_1234_FFFF_FFFF || lat !== 34) begin
      errors++;
      $display("FAIL divu_zero got %h_%h lat=%0d want 00001234_ffffffff lat=34", hi32, lo32, lat);
    end
    run32(2'b10, 32'hFFFF_FFFB, 32'd0, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'hFFFF_FFFB_FFFF_FFFF) begin
      errors++;
      $display("FAIL div_zero got %h_%h want fffffffb_ffffffff", hi32, lo32);
    end
  endtask

  task automatic test_handshake();
    int lat, bc;
    logic [31:0] prev_hi;
    tick();
    prev_hi = hi32;
    op32 = 2'b11; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (4) tick();
    op32 = 2'b01; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1;
    hw32 = 1'b1; wd32 = 32'hAA;
    tick();
    start32 = 1'b0; hw32 = 1'b0;
    checks++;
    if (hi32 !== prev_hi || busy32 !== 1'b1) begin
      errors++;
      $display("FAIL busy_write hi=%h busy=%b want hi=%h busy=1", hi32, busy32, prev_hi);
    end
    lat = 0;
    while (!done32 && lat < 100) begin tick(); lat++; end
    checks++;
    if ({hi32, lo32} !== 64'h0000_0002_0000_000E) begin
      errors++;
      $display("FAIL divu_busy_start got %h_%h want 00000002_0000000e", hi32, lo32);
    end
    repeat (3) tick();
    checks++;
    if (busy32 !== 1'b0 || {hi32, lo32} !== 64'h0000_0002_0000_000E) begin
      errors++;
      $display("FAIL no_queue busy=%b hi=%h lo=%h want 0/2/e", busy32, hi32, lo32);
    end
    hw32 = 1'b1; wd32 = 32'hAA;
    tick();
    hw32 = 1'b0;
    checks++;
    if (hi32 !== 32'hAA || lo32 !== 32'hE) begin
      errors++;
      $display("FAIL mthi_idle hi=%h lo=%h want aa/e", hi32, lo32);
    end
    hw32 = 1'b1; lw32 = 1'b1; wd32 = 32'h3C;
    tick();
    hw32 = 1'b0; lw32 = 1'b0;
    checks++;
    if (hi32 !== 32'h3C || lo32 !== 32'h3C) begin
      errors++;
      $display("FAIL mthi_mtlo hi=%h lo=%h want 3c/3c", hi32, lo32);
    end
    // start together with MTLO: the write is dropped
    op32 = 2'b01; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1;
    lw32 = 1'b1; wd32 = 32'h77;
    tick();
    start32 = 1'b0; lw32 = 1'b0;
    checks++;
    if (lo32 !== 32'h3C || busy32 !== 1'b1) begin
      errors++;
      $display("FAIL start_wins lo=%h busy=%b want 3c/1", lo32, busy32);
    end
    lat = 0;
    while (!done32 && lat < 100) begin tick(); lat++; end
    checks++;
    if ({hi32, lo32} !== 64'h0000_0000_0000_0006) begin
      errors++;
      $display("FAIL multu_after_start got %h_%h want 00000000_00000006", hi32, lo32);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    hw32 = 1'b1; lw32 = 1'b1; wd32 = 32'h5A5A;
    tick();
    hw32 = 1'b0; lw32 = 1'b0;
    op32 = 2'b00; a32 = 32'h12345; b32 = 32'hFFFF_FFF9; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h want all zero", busy32, done32, hi32, lo32);
    end
    repeat (40) tick();
    checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      errors++;
      $display("FAIL reset_abort busy=%b done=%b hi=%h lo=%h want all zero", busy32, done32, hi32, lo32);
    end
    run32(2'b01, 32'd6, 32'd7, -1, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'd42 || lat !== 34) begin
      errors++;
      $display("FAIL multu_after_reset got %h_%h lat=%0d want 0_2a lat=34", hi32, lo32, lat);
    end
  endtask

  task automatic test_enable();
    int lat, bc;
    run32(2'b01, 32'h0001_0000, 32'h0003_0001, 10, lat, bc);
    checks++;
    if ({hi32, lo32} !== 64'h0000_0003_0001_0000 || lat !== 39) begin
      errors++;
      $display("FAIL enable_stall got %h_%h lat=%0d want 00000003_00010000 lat=39", hi32, lo32, lat);
    end
  endtask

  task automatic test_sweep8();
    logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h55,
                             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};
    logic [15:0] want;
    int lat;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          run8(2'(o), vals[i], vals[j], lat);
          want = model8(2'(o), vals[i], vals[j]);
          checks++;
          if ({hi8, lo8} !== want || lat !== 10) begin
            errors++;
            $display("FAIL sweep8 op=%0d a=%h b=%h got %h_%h lat=%0d want %h_%h lat=10",
                     o, vals[i], vals[j], hi8, lo8, lat, want[15:8], want[7:0]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b1;
    start32 = 1'b0; hw32 = 1'b0; lw32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; wd32 = '0;
    start8 = 1'b0;  hw8 = 1'b0;  lw8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;  wd8 = '0;
    repeat (3) tick();
    test_reset();
    test_multu();
    test_signs();
    test_corner_div();
    test_handshake();
    test_reset_mid();
    test_enable();
    test_sweep8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
